// File: rtl/xadc_pkg.sv
// Shared XADC definitions: DRP register addresses and the DRP master FSM states.
package xadc_pkg;

  localparam logic [6:0] ADDR_CFG0     = 7'h40;
  localparam logic [6:0] ADDR_CFG1     = 7'h41;
  localparam logic [6:0] ADDR_SEQ_AUX  = 7'h49;
  localparam logic [6:0] ADDR_AUX_BASE = 7'h10;

  typedef enum logic [2:0] {
    S_INIT_WR,
    S_INIT_WAIT,
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT
  } state_e;

endpackage

// File: rtl/xadc_drp_master.sv
// DRP initiator for the XADC: programs three config registers after reset, then reads the
// status register of each channel reported on EOC and emits it as a tagged sample.
module xadc_drp_master
  import xadc_pkg::*;
#(
  parameter logic [15:0] CFG0_VAL     = 16'h0000,
  parameter logic [15:0] CFG1_VAL     = 16'h2000,
  parameter logic [15:0] SEQ_AUX_VAL  = 16'h00C0,
  parameter int unsigned DRDY_TIMEOUT = 64
) (
  input  logic        CLK100MHZ,
  input  logic        rst_n,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [15:0] sample_data,
  output logic [4:0]  sample_chan,
  output logic        sample_valid,
  output logic        init_done,
  output logic        timeout_err,
  output logic        overrun_err
);

  localparam int unsigned CNT_W = $clog2(DRDY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRDY_TIMEOUT - 1);

  state_e           r_state, w_state_d;
  logic [1:0]       r_idx, w_idx_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [4:0]       r_chan, w_chan_d;
  logic             r_pend, w_pend_d;
  logic [4:0]       r_pend_chan, w_pend_chan_d;
  logic             r_den, w_den_d;
  logic             r_dwe, w_dwe_d;
  logic [6:0]       r_daddr, w_daddr_d;
  logic [15:0]      r_di, w_di_d;
  logic [15:0]      r_sdata, w_sdata_d;
  logic [4:0]       r_schan, w_schan_d;
  logic             r_svalid, w_svalid_d;
  logic             r_init_done, w_init_done_d;
  logic             r_tmo, w_tmo_d;
  logic             r_ovr, w_ovr_d;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_timeout = (r_cnt == CNT_LAST);
  // Saturating increment so a stuck wait can never wrap back below the timeout threshold.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_d     = r_state;
    w_idx_d       = r_idx;
    w_cnt_d       = r_cnt;
    w_chan_d      = r_chan;
    w_pend_d      = r_pend;
    w_pend_chan_d = r_pend_chan;
    w_den_d       = 1'b0;
    w_dwe_d       = 1'b0;
    w_daddr_d     = r_daddr;
    w_di_d        = r_di;
    w_sdata_d     = r_sdata;
    w_schan_d     = r_schan;
    w_svalid_d    = 1'b0;
    w_init_done_d = r_init_done;
    w_tmo_d       = r_tmo;
    w_ovr_d       = r_ovr;

    unique case (r_state)
      S_INIT_WR: begin
        w_den_d = 1'b1;
        w_dwe_d = 1'b1;
        case (r_idx)
          2'd0: begin
            w_daddr_d = ADDR_CFG0;
            w_di_d    = CFG0_VAL;
          end
          2'd1: begin
            w_daddr_d = ADDR_CFG1;
            w_di_d    = CFG1_VAL;
          end
          default: begin
            w_daddr_d = ADDR_SEQ_AUX;
            w_di_d    = SEQ_AUX_VAL;
          end
        endcase
        w_cnt_d   = '0;
        w_state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (drp_drdy || w_timeout) begin
          if (!drp_drdy) w_tmo_d = 1'b1;
          if (r_idx == 2'd2) begin
            w_init_done_d = 1'b1;
            w_state_d     = S_IDLE;
          end else begin
            w_idx_d   = r_idx + 2'd1;
            w_state_d = S_INIT_WR;
          end
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      S_IDLE: begin
        if (r_pend) begin
          w_chan_d  = r_pend_chan;
          w_pend_d  = 1'b0;
          w_state_d = S_RD_REQ;
        end else if (eoc_in) begin
          w_chan_d  = channel_in;
          w_state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        w_den_d   = 1'b1;
        w_daddr_d = {2'b00, r_chan};
        w_cnt_d   = '0;
        w_state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (drp_drdy) begin
          w_sdata_d  = drp_do;
          w_schan_d  = r_chan;
          w_svalid_d = 1'b1;
          w_state_d  = S_IDLE;
        end else if (w_timeout) begin
          w_tmo_d   = 1'b1;
          w_state_d = S_IDLE;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      default: w_state_d = S_INIT_WR;
    endcase

    // One-deep EOC queue; an EOC in S_IDLE while serving the pending entry takes its slot.
    if (eoc_in && r_init_done) begin
      if (r_state != S_IDLE) begin
        if (r_pend) w_ovr_d = 1'b1;
        w_pend_d      = 1'b1;
        w_pend_chan_d = channel_in;
      end else if (r_pend) begin
        w_pend_d      = 1'b1;
        w_pend_chan_d = channel_in;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT_WR;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_chan      <= 5'd0;
      r_pend      <= 1'b0;
      r_pend_chan <= 5'd0;
      r_den       <= 1'b0;
      r_dwe       <= 1'b0;
      r_daddr     <= 7'd0;
      r_di        <= 16'd0;
      r_sdata     <= 16'd0;
      r_schan     <= 5'd0;
      r_svalid    <= 1'b0;
      r_init_done <= 1'b0;
      r_tmo       <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_cnt       <= w_cnt_d;
      r_chan      <= w_chan_d;
      r_pend      <= w_pend_d;
      r_pend_chan <= w_pend_chan_d;
      r_den       <= w_den_d;
      r_dwe       <= w_dwe_d;
      r_daddr     <= w_daddr_d;
      r_di        <= w_di_d;
      r_sdata     <= w_sdata_d;
      r_schan     <= w_schan_d;
      r_svalid    <= w_svalid_d;
      r_init_done <= w_init_done_d;
      r_tmo       <= w_tmo_d;
      r_ovr       <= w_ovr_d;
    end
  end

  assign drp_daddr    = r_daddr;
  assign drp_den      = r_den;
  assign drp_dwe      = r_dwe;
  assign drp_di       = r_di;
  assign sample_data  = r_sdata;
  assign sample_chan  = r_schan;
  assign sample_valid = r_svalid;
  assign init_done    = r_init_done;
  assign timeout_err  = r_tmo;
  assign overrun_err  = r_ovr;

endmodule

// File: tb/tb_xadc_drp_master.sv
// Scoreboard bench for xadc_drp_master: behavioural DRP responder, expected DRP transfers and
// samples queued by the stimulus, popped and compared by independent monitors.
module tb_xadc_drp_master;

  localparam int unsigned TMO = 64;

  typedef struct {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] di;
  } txn_t;

  typedef struct {
    logic [4:0]  ch;
    logic [15:0] d;
  } samp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eoc_in = 1'b0;
  logic [4:0]  channel_in = 5'd0;
  logic [15:0] drp_do = 16'd0;
  logic        drp_drdy = 1'b0;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] sample_data;
  logic [4:0]  sample_chan;
  logic        sample_valid;
  logic        init_done;
  logic        timeout_err;
  logic        overrun_err;

  always #5 clk = ~clk;

  xadc_drp_master dut (
    .CLK100MHZ   (clk),
    .rst_n       (rst_n),
    .eoc_in      (eoc_in),
    .channel_in  (channel_in),
    .drp_daddr   (drp_daddr),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_di      (drp_di),
    .drp_do      (drp_do),
    .drp_drdy    (drp_drdy),
    .sample_data (sample_data),
    .sample_chan (sample_chan),
    .sample_valid(sample_valid),
    .init_done   (init_done),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  int checks = 0;
  int errors = 0;

  txn_t  exp_drp[$];
  samp_t exp_samp[$];
  logic [15:0] mem [128];
  logic m_tmo = 1'b0;
  logic m_ovr = 1'b0;

  int   resp_delay = 2;
  bit   no_resp = 1'b0;
  bit   resp_busy = 1'b0;
  int   resp_left = 0;
  logic [15:0] resp_data = 16'd0;
  logic prev_den = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // DRP responder: drdy pulses resp_delay cycles after the den cycle; reads return mem[addr].
  initial begin
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      if (!rst_n) begin
        resp_busy = 1'b0;
      end else begin
        if (resp_busy) begin
          resp_left--;
          if (resp_left == 0) begin
            drp_drdy  = 1'b1;
            drp_do    = resp_data;
            resp_busy = 1'b0;
          end
        end
        if (drp_den && !no_resp) begin
          resp_busy = 1'b1;
          resp_left = resp_delay;
          resp_data = drp_dwe ? 16'h0000 : mem[drp_daddr];
        end
      end
    end
  end

  // DRP transfer monitor.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (rst_n && drp_den) begin
        chk("den_single_cycle", {31'd0, prev_den}, 32'd0);
        if (exp_drp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drp_unexpected actual addr=%0h we=%0b required none", drp_daddr, drp_dwe);
        end else begin
          t = exp_drp.pop_front();
          chk("drp_addr", {25'd0, drp_daddr}, {25'd0, t.addr});
          chk("drp_we", {31'd0, drp_dwe}, {31'd0, t.we});
          if (t.we) chk("drp_di", {16'd0, drp_di}, {16'd0, t.di});
        end
      end else if (rst_n && prev_den) begin
        chk("dwe_after_den", {31'd0, drp_dwe}, 32'd0);
      end
      prev_den = drp_den;
    end
  end

  // Sample monitor.
  initial begin
    samp_t s;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        if (exp_samp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sample_unexpected actual chan=%0d data=%0h required none",
                   sample_chan, sample_data);
        end else begin
          s = exp_samp.pop_front();
          chk("sample_chan", {27'd0, sample_chan}, {27'd0, s.ch});
          chk("sample_data", {16'd0, sample_data}, {16'd0, s.d});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_eoc(input logic [4:0] ch);
    eoc_in     = 1'b1;
    channel_in = ch;
    @(negedge clk);
    eoc_in = 1'b0;
  endtask

  task automatic push_init();
    exp_drp.push_back('{addr: 7'h40, we: 1'b1, di: 16'h0000});
    exp_drp.push_back('{addr: 7'h41, we: 1'b1, di: 16'h2000});
    exp_drp.push_back('{addr: 7'h49, we: 1'b1, di: 16'h00C0});
  endtask

  task automatic push_read(input logic [4:0] ch, input bit with_sample);
    exp_drp.push_back('{addr: {2'b00, ch}, we: 1'b0, di: 16'h0000});
    if (with_sample) exp_samp.push_back('{ch: ch, d: mem[{2'b00, ch}]});
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("init_done", {31'd0, init_done}, 32'd1);
    chk("init_writes_done", exp_drp.size(), 32'd0);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_drp_drained"}, exp_drp.size(), 32'd0);
    chk({tag, "_samples_drained"}, exp_samp.size(), 32'd0);
    chk({tag, "_overrun_err"}, {31'd0, overrun_err}, {31'd0, m_ovr});
    chk({tag, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, m_tmo});
  endtask

  // One EOC while idle, then k more while the read is outstanding: only the last extra is kept.
  task automatic read_iter(input logic [4:0] ch, input int d, input int k,
                           input logic [4:0] e0, input logic [4:0] e1, input logic [4:0] e2);
    logic [4:0] last;
    resp_delay = d;
    push_read(ch, 1'b1);
    pulse_eoc(ch);
    last = ch;
    if (k >= 1) begin pulse_eoc(e0); last = e0; end
    if (k >= 2) begin pulse_eoc(e1); last = e1; end
    if (k >= 3) begin pulse_eoc(e2); last = e2; end
    if (k >= 1) push_read(last, 1'b1);
    if (k >= 2) m_ovr = 1'b1;
    tick(2 * d + 16);
    check_flags("read");
  endtask

  initial begin
    int n;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);

    // Reset values
    tick(2);
    chk("rst_den", {31'd0, drp_den}, 32'd0);
    chk("rst_dwe", {31'd0, drp_dwe}, 32'd0);
    chk("rst_daddr", {25'd0, drp_daddr}, 32'd0);
    chk("rst_di", {16'd0, drp_di}, 32'd0);
    chk("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);

    // Init sequence, with EOCs arriving mid-init that must be dropped
    push_init();
    resp_delay = 2;
    rst_n = 1'b1;
    tick(3);
    pulse_eoc(5'd5);
    pulse_eoc(5'd6);
    chk("init_done_early", {31'd0, init_done}, 32'd0);
    wait_init();
    tick(10);
    check_flags("init");

    // Single read of aux6
    mem[7'h16] = 16'hA5F0;
    read_iter(5'd22, 2, 0, 5'd0, 5'd0, 5'd0);

    // Overrun: ch23 then ch16 while ch22 read is outstanding
    read_iter(5'd22, 10, 2, 5'd23, 5'd16, 5'd0);

    // Responder silent: the read must be abandoned after DRDY_TIMEOUT cycles
    no_resp = 1'b1;
    push_read(5'd7, 1'b0);
    pulse_eoc(5'd7);
    n = 0;
    while (!drp_den && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_den_seen", {31'd0, drp_den}, 32'd1);
    tick(TMO - 4);
    chk("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
    tick(6);
    chk("tmo_set", {31'd0, timeout_err}, 32'd1);
    m_tmo = 1'b1;
    no_resp = 1'b0;
    read_iter(5'd3, 3, 0, 5'd0, 5'd0, 5'd0);

    // Randomized reads with random drdy latency and random overlapping EOC bursts
    for (int i = 0; i < 10; i++) begin
      read_iter(5'($urandom_range(0, 31)), int'($urandom_range(2, 12)),
                int'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Reset during an outstanding read
    resp_delay = 10;
    push_read(5'd9, 1'b0);
    pulse_eoc(5'd9);
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_den", {31'd0, drp_den}, 32'd0);
    chk("arst_daddr", {25'd0, drp_daddr}, 32'd0);
    chk("arst_di", {16'd0, drp_di}, 32'd0);
    chk("arst_sample_data", {16'd0, sample_data}, 32'd0);
    chk("arst_sample_chan", {27'd0, sample_chan}, 32'd0);
    chk("arst_sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("arst_init_done", {31'd0, init_done}, 32'd0);
    chk("arst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("arst_overrun_err", {31'd0, overrun_err}, 32'd0);
    m_tmo = 1'b0;
    m_ovr = 1'b0;
    tick(3);
    push_init();
    resp_delay = 2;
    rst_n = 1'b1;
    wait_init();
    tick(10);
    check_flags("reinit");
    read_iter(5'd17, 4, 1, 5'd18, 5'd0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
